seg_scan_driver: RTL and testbench

Consumer end of the 500 Hz scan clock produced by the team's clock divider. It synchronises that divided clock into the system clock domain, detects its rising edges, and uses each edge to time-multiplex four BCD digits onto a common-anode 4-digit seven-segment display. It also provides inter-digit blanking, leading-zero suppression and frame-coherent digit capture for the egg-timer display path.

---
 rtl/seg_scan_driver.sv | 111 +++++++++++
 tb/tb_seg_scan_driver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode seven-segment scanner stepped by rising edges of a
// slow, asynchronous scan clock, with anti-ghost blanking and per-frame digit capture.
module seg_scan_driver #(
    parameter int BLANK_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_clk,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lead,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [15:0] BLANK_INIT = 16'(BLANK_CYCLES);

    logic        r_s1;
    logic        r_s2;
    logic        r_s3;
    logic [1:0]  r_idx;
    logic [15:0] r_blank_cnt;
    logic [15:0] r_snap;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;

    logic        w_rise;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg;
    logic        w_suppress;
    logic        w_dark;
    logic [3:0]  w_an_lit;

    assign w_rise   = r_s2 & ~r_s3;
    assign w_nib    = r_snap[{r_idx, 2'b00} +: 4];
    assign w_an_lit = ~(4'b0001 << r_idx);

    always_comb begin
        w_seg = 7'b0111111;
        case (w_nib)
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = 7'b0111111;
        endcase
    end

    // Dash codes (10..15) are non-zero, so they never count as leading zeros.
    always_comb begin
        w_suppress = 1'b0;
        if (blank_lead) begin
            if (r_idx == 2'd3)
                w_suppress = (r_snap[15:12] == 4'd0);
            else if (r_idx == 2'd2)
                w_suppress = (r_snap[15:12] == 4'd0) && (r_snap[11:8] == 4'd0);
        end
    end

    assign w_dark = (r_blank_cnt != 16'd0) | ~enable | w_suppress;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_idx       <= 2'd0;
            r_blank_cnt <= 16'd0;
            r_snap      <= 16'h0000;
            r_an        <= 4'b1111;
            r_seg       <= 7'h7F;
            r_dp        <= 1'b1;
        end else begin
            r_s1 <= scan_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (w_rise) begin
                // Capture the next frame exactly as the index wraps back to digit 0.
                if (r_idx == 2'd3)
                    r_snap <= digits;
                r_idx       <= r_idx + 2'd1;
                r_blank_cnt <= BLANK_INIT;
            end else if (r_blank_cnt != 16'd0) begin
                r_blank_cnt <= r_blank_cnt - 16'd1;
            end
            if (w_dark) begin
                r_an  <= 4'b1111;
                r_seg <= 7'h7F;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= w_an_lit;
                r_seg <= w_seg;
                r_dp  <= ~dp_mask[r_idx];
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: an event-timeline model predicts {an,seg,dp} for
// every clock edge into a queue; a monitor pops and compares on the falling edge.
module tb_seg_scan_driver;

    localparam int B = 4;
    localparam logic [11:0] RST_OUT = {4'b1111, 7'h7F, 1'b1};
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    logic        clk;
    logic        rst;
    logic        scan_clk;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        blank_lead;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] exp_q[$];

    seg_scan_driver #(.BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_clk   (scan_clk),
        .enable     (enable),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blank_lead (blank_lead),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scan clock generator ----------------
    int scan_half = 2;
    int scan_cnt  = 0;
    initial begin
        scan_clk = 1'b0;
        forever begin
            @(negedge clk);
            scan_cnt++;
            if (scan_cnt >= scan_half) begin
                scan_cnt = 0;
                scan_clk = ~scan_clk;
            end
        end
    end

    // ---------------- reference model ----------------
    // Timeline view: edge numbers are counted; scan_clk samples are logged per edge.
    // A digit step lands two edges after the first edge that samples scan_clk high
    // (following a low sample); samples at or before the latest reset count as low.
    int          m_edge     = 0;
    int          m_last_rst = 0;
    int          m_upd_cnt  = 0;
    int          m_last_upd = 0;
    bit          m_have_upd = 0;
    logic [15:0] m_snap     = 16'h0000;
    bit          m_samp[int];
    logic [11:0] m_e;

    function automatic bit sample_at(int k);
        if (k <= m_last_rst) return 1'b0;
        return m_samp[k];
    endfunction

    function automatic logic [11:0] model_out();
        int         idx;
        logic [3:0] nib;
        logic [3:0] a;
        bit         blanked;
        bit         sup;
        idx     = m_upd_cnt % 4;
        nib     = m_snap[idx*4 +: 4];
        blanked = m_have_upd && ((m_edge - m_last_upd) <= B);
        sup     = blank_lead && ((idx == 3 && m_snap[15:12] == 4'd0) ||
                                 (idx == 2 && m_snap[15:8] == 8'd0));
        if (blanked || !enable || sup) return RST_OUT;
        a      = 4'b1111;
        a[idx] = 1'b0;
        return {a, SEG_TAB[nib], ~dp_mask[idx]};
    endfunction

    always @(posedge clk) begin
        m_edge++;
        if (!rst) begin
            m_e        = RST_OUT;
            m_last_rst = m_edge;
            m_upd_cnt  = 0;
            m_have_upd = 0;
            m_snap     = 16'h0000;
        end else begin
            m_e = model_out();
            if (sample_at(m_edge - 2) && !sample_at(m_edge - 3)) begin
                if (m_upd_cnt % 4 == 3) m_snap = digits;
                m_upd_cnt++;
                m_last_upd = m_edge;
                m_have_upd = 1;
            end
        end
        m_samp[m_edge] = scan_clk;
        exp_q.push_back(m_e);
    end

    // ---------------- monitor / scoreboard ----------------
    logic [11:0] mon_exp;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            n_tests++;
            if ({an, seg, dp} !== mon_exp) begin
                n_fail++;
                $display("FAIL out edge=%0d got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                         m_edge, an, seg, dp, mon_exp[11:8], mon_exp[7:1], mon_exp[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idx(input int want, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (m_upd_cnt % 4 == want) begin
                ok = 1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s got timeout expected idx=%0d", name, want);
        end
    endtask

    task automatic wait_blanking(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (m_have_upd && (m_edge - m_last_upd) == 2) begin
                ok = 1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s got timeout expected mid-blank", name);
        end
    endtask

    task automatic pulse_reset(input int n);
        rst = 1'b0;
        wait_clks(n);
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] r;
        rst        = 1'b0;
        enable     = 1'b1;
        digits     = 16'h0000;
        dp_mask    = 4'b0000;
        blank_lead = 1'b0;
        scan_half  = 1;

        // Reset held for 3 clocks while scan_clk toggles.
        wait_clks(3);
        rst = 1'b1;

        // Rotation over 1234 with a 40-clock scan period.
        scan_half = 20;
        digits    = 16'h1234;
        wait_clks(500);

        // Decode sweep on digit 0, fast scan.
        scan_half = 5;
        for (int v = 0; v < 16; v++) begin
            digits = {12'h000, 4'(v)};
            wait_clks(100);
        end

        // Leading-zero suppression.
        blank_lead = 1'b1;
        dp_mask    = 4'b1000;
        digits     = 16'h0005;
        wait_clks(120);
        dp_mask    = 4'b0101;
        digits     = 16'h0105;
        wait_clks(120);
        digits     = 16'h0A05;
        wait_clks(120);
        blank_lead = 1'b0;

        // Snapshot coherence: change input while digit 1 is active.
        scan_half = 20;
        digits    = 16'h0959;
        wait_clks(400);
        wait_idx(1, "wait_idx1");
        digits = 16'h1000;
        wait_clks(400);

        // Enable dropped for 100 clocks.
        enable = 1'b0;
        wait_clks(100);
        enable = 1'b1;
        wait_clks(200);

        // Reset mid-blank.
        wait_blanking("wait_blank");
        pulse_reset(1);
        wait_clks(300);

        // Randomized segments, including fast rises that land during blanking.
        for (int it = 0; it < 25; it++) begin
            r = 16'($urandom);
            if ($urandom_range(0, 1) == 1) r[15:12] = 4'd0;
            if ($urandom_range(0, 1) == 1) r[11:8]  = 4'd0;
            digits     = r;
            dp_mask    = 4'($urandom_range(0, 15));
            blank_lead = 1'($urandom_range(0, 1));
            enable     = ($urandom_range(0, 3) != 0);
            scan_half  = $urandom_range(1, 25);
            if ($urandom_range(0, 4) == 0) pulse_reset($urandom_range(1, 3));
            wait_clks($urandom_range(50, 300));
        end

        wait_clks(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
